// File: rtl/neuron_param_tx.sv
// neuron_param_tx: nibble-serial transmitter for the neuron parameter-load interface.
// Sends Vreset, VT, Ibias and C (in that order) as arm, hi/lo nibble pairs with latch gaps,
// then a release period with load_mode low. All outputs are registered.
// Optional build macro NEURON_PARAM_TX_DOUBLE_SEND_EN: each request sends the frame twice.
module neuron_param_tx #(
  parameter int unsigned GAP_CYCLES     = 1,
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] p_vreset,
  input  logic [7:0] p_vt,
  input  logic [7:0] p_ibias,
  input  logic [7:0] p_c,
  output logic       busy,
  output logic       done,
  output logic       load_mode,
  output logic       load_enable,
  output logic [3:0] nibble_out
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StHi,
    StLo,
    StGap,
    StRelease
  } state_e;

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] RelLast = 4'(RELEASE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        done_d, busy_d, mode_d, en_d;
  logic [3:0]  nib_d;
  logic [7:0]  cur_byte;
`ifdef NEURON_PARAM_TX_DOUBLE_SEND_EN
  logic        pass_q, pass_d;
`endif

  // State, counters, holding register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      data_q      <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_mode   <= 1'b0;
      load_enable <= 1'b0;
      nibble_out  <= 4'd0;
`ifdef NEURON_PARAM_TX_DOUBLE_SEND_EN
      pass_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      busy        <= busy_d;
      done        <= done_d;
      load_mode   <= mode_d;
      load_enable <= en_d;
      nibble_out  <= nib_d;
`ifdef NEURON_PARAM_TX_DOUBLE_SEND_EN
      pass_q      <= pass_d;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register with it
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef NEURON_PARAM_TX_DOUBLE_SEND_EN
    pass_d  = pass_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StArm;
          idx_d   = 2'd0;
          data_d  = {p_vreset, p_vt, p_ibias, p_c};
`ifdef NEURON_PARAM_TX_DOUBLE_SEND_EN
          pass_d  = 1'b0;
`endif
        end
      end
      StArm: state_d = StHi;
      StHi:  state_d = StLo;
      StLo: begin
        state_d = StGap;
        cnt_d   = 4'd0;
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = 4'd0;
          if (idx_q == 2'd3) begin
            state_d = StRelease;
          end else begin
            state_d = StHi;
            idx_d   = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRelease: begin
        if (cnt_q == RelLast) begin
          cnt_d = 4'd0;
`ifdef NEURON_PARAM_TX_DOUBLE_SEND_EN
          // Second pass reuses the latched bytes; done only after it
          if (!pass_q) begin
            state_d = StArm;
            idx_d   = 2'd0;
            pass_d  = 1'b1;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
`else
          state_d = StIdle;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    case (idx_d)
      2'd0:    cur_byte = data_d[31:24];
      2'd1:    cur_byte = data_d[23:16];
      2'd2:    cur_byte = data_d[15:8];
      default: cur_byte = data_d[7:0];
    endcase

    busy_d = (state_d != StIdle);
    mode_d = 1'b0;
    en_d   = 1'b0;
    nib_d  = 4'd0;
    case (state_d)
      StArm: begin
        mode_d = 1'b1;
        en_d   = 1'b1;
      end
      StHi: begin
        mode_d = 1'b1;
        en_d   = 1'b1;
        nib_d  = cur_byte[7:4];
      end
      StLo: begin
        mode_d = 1'b1;
        en_d   = 1'b1;
        nib_d  = cur_byte[3:0];
      end
      StGap:   mode_d = 1'b1;
      default: mode_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_neuron_param_tx.sv
// Self-checking bench for neuron_param_tx: table-driven frames checked cycle by cycle
// through an expected-output queue, plus start-hold, mid-frame reset and custom-timing cases.
module tb_neuron_param_tx;

  localparam int G  = 1;
  localparam int R  = 2;
  localparam int G2 = 3;
  localparam int R2 = 1;
`ifdef NEURON_PARAM_TX_DOUBLE_SEND_EN
  localparam int Passes = 2;
`else
  localparam int Passes = 1;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mode;
    logic       en;
    logic [3:0] nib;
  } outs_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [35:0] nibs;  // first nine en=1 nibbles, first in the top position
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] p_vreset = 8'd0, p_vt = 8'd0, p_ibias = 8'd0, p_c = 8'd0;
  logic       busy, done, load_mode, load_enable;
  logic [3:0] nibble_out;
  logic       busy2, done2, load_mode2, load_enable2;
  logic [3:0] nibble_out2;

  int n_cmp = 0;
  int n_fail = 0;
  outs_t exp_q[$];

  always #5 clk = ~clk;

  neuron_param_tx dut (
    .clk(clk), .reset(reset), .start(start),
    .p_vreset(p_vreset), .p_vt(p_vt), .p_ibias(p_ibias), .p_c(p_c),
    .busy(busy), .done(done), .load_mode(load_mode), .load_enable(load_enable),
    .nibble_out(nibble_out)
  );

  neuron_param_tx #(.GAP_CYCLES(G2), .RELEASE_CYCLES(R2)) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .p_vreset(p_vreset), .p_vt(p_vt), .p_ibias(p_ibias), .p_c(p_c),
    .busy(busy2), .done(done2), .load_mode(load_mode2), .load_enable(load_enable2),
    .nibble_out(nibble_out2)
  );

  function automatic outs_t mk(logic b, logic d, logic m, logic e, logic [3:0] n);
    outs_t o;
    o.busy = b; o.done = d; o.mode = m; o.en = e; o.nib = n;
    return o;
  endfunction

  function automatic outs_t cur_outs();
    return mk(busy, done, load_mode, load_enable, nibble_out);
  endfunction

  task automatic check_outs(string name, outs_t act, outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b mode=%b en=%b nib=%h, want busy=%b done=%b mode=%b en=%b nib=%h",
               name, act.busy, act.done, act.mode, act.en, act.nib,
               exp.busy, exp.done, exp.mode, exp.en, exp.nib);
    end
  endtask

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected trace after each edge E0.. for one accepted request
  function automatic void push_frame(logic [7:0] b0, b1, b2, b3, bit restart);
    logic [31:0] w;
    logic [7:0]  b;
    w = {b0, b1, b2, b3};
    for (int p = 0; p < Passes; p++) begin
      exp_q.push_back(mk(1, 0, 1, 1, 4'h0));
      for (int k = 0; k < 4; k++) begin
        b = w[31-8*k -: 8];
        exp_q.push_back(mk(1, 0, 1, 1, b[7:4]));
        exp_q.push_back(mk(1, 0, 1, 1, b[3:0]));
        for (int g = 0; g < G; g++) exp_q.push_back(mk(1, 0, 1, 0, 4'h0));
      end
      for (int r = 0; r < R; r++) exp_q.push_back(mk(1, 0, 0, 0, 4'h0));
    end
    exp_q.push_back(mk(0, 1, 0, 0, 4'h0));
    if (restart) exp_q.push_back(mk(1, 0, 1, 1, 4'h0));
    else         exp_q.push_back(mk(0, 0, 0, 0, 4'h0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start is high before E0 and stays high for hold edges; scramble inputs once started
  task automatic run_queue(string name, int hold, bit scramble, output logic [35:0] nibs);
    outs_t e;
    int    edge_n;
    int    n_seen;
    nibs   = '0;
    n_seen = 0;
    edge_n = 0;
    start  = 1'b1;
    while (exp_q.size() > 0) begin
      tick();
      edge_n++;
      e = exp_q.pop_front();
      check_outs($sformatf("%s_E%0d", name, edge_n - 1), cur_outs(), e);
      if (load_enable && n_seen < 9) begin
        nibs = {nibs[31:0], nibble_out};
        n_seen++;
      end
      if (edge_n >= hold) start = 1'b0;
      if (scramble) begin
        p_vreset = 8'($urandom); p_vt = 8'($urandom);
        p_ibias  = 8'($urandom); p_c  = 8'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (busy) begin
      n_fail++;
      $display("FAIL %s: busy still 1 after 200 cycles, want 0", name);
    end
    tick();
  endtask

  vec_t        vecs[4];
  logic [35:0] got_nibs;
  int          len2;

  initial begin
    vecs[0] = '{8'h3F, 8'h4E, 8'h9E, 8'h64, 36'h03F4E9E64};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 36'h000000000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 36'h0FFFFFFFF};
    vecs[3] = '{8'hA5, 8'h5A, 8'h12, 8'hEF, 36'h0A55A12EF};

    // Reset and idle
    #12;
    check_outs("reset", cur_outs(), mk(0, 0, 0, 0, 4'h0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs($sformatf("idle%0d", i), cur_outs(), mk(0, 0, 0, 0, 4'h0));
    end

    // Table-driven frames; inputs scrambled during the frame must not matter
    for (int v = 0; v < 4; v++) begin
      p_vreset = vecs[v].b0; p_vt = vecs[v].b1; p_ibias = vecs[v].b2; p_c = vecs[v].b3;
      push_frame(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, 1'b0);
      run_queue($sformatf("vec%0d", v), 1, (v != 0), got_nibs);
      check_val($sformatf("vec%0d_nibbles", v), 64'(got_nibs), 64'(vecs[v].nibs));
    end

    // start held high 20 cycles: re-accept at the idle/done cycle, not earlier
    p_vreset = 8'h12; p_vt = 8'h34; p_ibias = 8'h56; p_c = 8'h78;
    push_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
    run_queue("hold", 20, 1'b0, got_nibs);
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    wait_idle("hold_drain");
    check_outs("hold_after", cur_outs(), mk(0, 0, 0, 0, 4'h0));

    // Reset during byte 2 HI: outputs drop within the cycle
    p_vreset = 8'h3F; p_vt = 8'h4E; p_ibias = 8'h9E; p_c = 8'h64;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check_outs("pre_reset_hi2", cur_outs(), mk(1, 0, 1, 1, 4'h9));
    #2 reset = 1'b1;
    #1;
    check_outs("async_reset", cur_outs(), mk(0, 0, 0, 0, 4'h0));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) tick();
    check_outs("post_reset_idle", cur_outs(), mk(0, 0, 0, 0, 4'h0));

    // GAP_CYCLES=3, RELEASE_CYCLES=1 instance: 22-cycle frame
    len2 = Passes * (1 + 4 * (2 + G2) + R2);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check_val("g3_busy_E0", 64'(busy2), 64'd1);
    for (int e = 1; e <= len2 + 1; e++) begin
      tick();
      check_val($sformatf("g3_done_E%0d", e), 64'(done2), 64'(e == len2));
      check_val($sformatf("g3_busy_E%0d", e), 64'(busy2), 64'(e < len2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
